// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage and its buffer.
package fetch_unit_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int ADDR_WIDTH  = 32;
    localparam int ENTRY_WIDTH = ADDR_WIDTH + INSTR_WIDTH;

    localparam logic [INSTR_WIDTH-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_t;

    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
        return a & ~ADDR_WIDTH'(3);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ICache request, decode handshake and redirect signals of the fetch stage.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic                   read_request;
    logic [ADDR_WIDTH-1:0]  addr;
    logic                   read_response;
    logic [INSTR_WIDTH-1:0] read_data;

    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instr_data;
    logic [ADDR_WIDTH-1:0]  instr_pc;

    logic                   redirect;
    logic [ADDR_WIDTH-1:0]  redirect_pc;

    modport master (
        output read_request, addr, instr_valid, instr_data, instr_pc,
        input  read_response, read_data, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  read_request, addr, instr_valid, instr_data, instr_pc,
        output read_response, read_data, instr_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small instruction buffer holding {pc, instr} entries toward decode, with flush.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int FIFO_DEPTH = 2,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [ENTRY_WIDTH-1:0] push_entry,
    input  logic                   pop_ready,
    output logic                   head_valid,
    output logic [ENTRY_WIDTH-1:0] head_entry,
    output logic [CNT_W-1:0]       count
);

    logic [ENTRY_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   pop;

    assign head_valid = (count != '0);
    assign pop        = head_valid && pop_ready;
    // Empty head reads as zero so decode never sees stale storage.
    assign head_entry = head_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues one ICache read at a time and buffers results.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int                    FIFO_DEPTH   = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  push;
    logic                  flush;
    logic                  has_space;
    logic [CNT_W-1:0]      fifo_count;
    logic [ENTRY_WIDTH-1:0] head_entry;

    assign redirect_target = word_align(bus.redirect_pc);
    assign has_space       = (fifo_count < CNT_W'(FIFO_DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH_IDLE;
            pc_q     <= RESET_VECTOR;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    // Leaving REQ/DROP always passes through IDLE, which gives the ICache its idle gap.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        flush    = 1'b0;
        unique case (state_q)
            FETCH_IDLE: begin
                if (bus.redirect) begin
                    pc_d  = redirect_target;
                    flush = 1'b1;
                end else if (has_space) begin
                    req_pc_d = pc_q;
                    state_d  = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (bus.redirect) begin
                    pc_d    = redirect_target;
                    flush   = 1'b1;
                    state_d = bus.read_response ? FETCH_IDLE : FETCH_DROP;
                end else if (bus.read_response) begin
                    push    = 1'b1;
                    pc_d    = pc_q + ADDR_WIDTH'(4);
                    state_d = FETCH_IDLE;
                end
            end
            FETCH_DROP: begin
                if (bus.redirect) begin
                    pc_d  = redirect_target;
                    flush = 1'b1;
                end
                if (bus.read_response) begin
                    state_d = FETCH_IDLE;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    assign bus.read_request = (state_q != FETCH_IDLE);
    assign bus.addr         = req_pc_q;

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push       (push),
        .push_entry ({req_pc_q, bus.read_data}),
        .pop_ready  (bus.instr_ready),
        .head_valid (bus.instr_valid),
        .head_entry (head_entry),
        .count      (fifo_count)
    );

    assign bus.instr_pc   = head_entry[ENTRY_WIDTH-1:INSTR_WIDTH];
    assign bus.instr_data = head_entry[INSTR_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: ICache model, randomized decode/redirect traffic.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int DEPTH   = 2;
    localparam int R_AUTO  = 0;
    localparam int R_FORCE = 1;
    localparam int R_HOLD  = 2;

    logic clk = 1'b0;
    logic reset;

    fetch_unit_if bus();

    fetch_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          test_cnt = 0;
    int          fail_cnt = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_pc   = 32'h0;
    bit          stale      = 1'b0;
    bit          prev_req   = 1'b0;
    bit          prev_resp  = 1'b0;
    bit          prev_redir = 1'b0;
    logic [31:0] prev_addr  = 32'h0;
    logic [31:0] prev_tgt   = 32'h0;
    int          prev_cnt   = 0;
    int          wait_cnt   = 0;
    int          lat        = 0;
    bit          hold_en    = 1'b0;
    logic [31:0] hold_addr  = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a >> 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        test_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decode side: compare the head against the oldest expected entry, pop on handshake.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("instr_valid", 32'(bus.instr_valid), 32'(exp_q.size() != 0));
            if (bus.instr_valid && exp_q.size() != 0) begin
                chk("instr_pc", bus.instr_pc, exp_q[0][63:32]);
                chk("instr_data", bus.instr_data, exp_q[0][31:0]);
                if (bus.instr_ready && !bus.redirect) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt, input int rmode);
        bit exp_req;
        bit resp;
        @(posedge clk);
        #1;
        // Apply last cycle's outcome to the reference model.
        if (prev_redir) begin
            exp_q.delete();
            model_pc = prev_tgt & ~32'd3;
            stale    = prev_req && !prev_resp;
        end else if (prev_req && prev_resp) begin
            if (!stale) begin
                exp_q.push_back({model_pc, mem_word(model_pc)});
                model_pc = model_pc + 32'd4;
            end
            stale = 1'b0;
        end

        exp_req = prev_req ? !prev_resp : (prev_cnt < DEPTH && !prev_redir);
        chk("read_request", 32'(bus.read_request), 32'(exp_req));
        if (bus.read_request && prev_req) begin
            chk("addr_stable", bus.addr, prev_addr);
        end
        if (bus.read_request && !prev_req) begin
            chk("req_addr", bus.addr, model_pc);
            wait_cnt = 0;
            lat      = $urandom_range(0, 3);
        end

        resp = 1'b0;
        if (bus.read_request) begin
            if (rmode == R_HOLD || (hold_en && bus.addr == hold_addr)) resp = 1'b0;
            else if (rmode == R_FORCE) resp = 1'b1;
            else resp = (wait_cnt >= lat);
            if (!resp) wait_cnt++;
            bus.read_response = resp;
            bus.read_data     = mem_word(bus.addr);
        end else begin
            bus.read_response = ($urandom_range(0, 7) == 0);
            bus.read_data     = NOP;
        end
        bus.instr_ready = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = tgt;

        prev_req   = bus.read_request;
        prev_addr  = bus.addr;
        prev_resp  = resp;
        prev_redir = redir;
        prev_tgt   = tgt;
        prev_cnt   = exp_q.size();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        exp_q.delete();
        model_pc   = 32'h0;
        stale      = 1'b0;
        prev_req   = 1'b0;
        prev_resp  = 1'b0;
        prev_redir = 1'b0;
        prev_cnt   = 0;
        hold_en    = 1'b0;
        bus.read_response = 1'b0;
        bus.read_data     = 32'h0;
        bus.redirect      = 1'b0;
        bus.redirect_pc   = 32'h0;
        bus.instr_ready   = 1'b0;
        #1;
        chk("rst_read_request", 32'(bus.read_request), 32'h0);
        chk("rst_addr", bus.addr, 32'h0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_instr_data", bus.instr_data, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_hold(input logic [31:0] a);
        bit hit;
        hit       = 1'b0;
        hold_en   = 1'b1;
        hold_addr = a;
        for (int i = 0; i < 40 && !hit; i++) begin
            step(1'b1, 1'b0, 32'h0, R_FORCE);
            hit = bus.read_request && (bus.addr == a);
        end
        chk("reach_addr", 32'(hit), 32'h1);
    endtask

    initial begin
        bit          rdy;
        bit          redir;
        logic [31:0] tgt;

        do_reset();

        // Sequential stream from the reset vector.
        repeat (14) step(1'b1, 1'b0, 32'h0, R_FORCE);

        // Decode stalled: buffer fills, requests stop, address stays put.
        repeat (20) step(1'b0, 1'b0, 32'h0, R_FORCE);
        chk("stall_no_req", 32'(bus.read_request), 32'h0);
        chk("stall_addr", bus.addr, model_pc - 32'd4);
        repeat (10) step(1'b1, 1'b0, 32'h0, R_FORCE);

        // Redirect while a request is outstanding: that word is dropped.
        step(1'b1, 1'b1, 32'h0, R_FORCE);
        wait_hold(32'h8);
        step(1'b1, 1'b1, 32'h40, R_HOLD);
        hold_en = 1'b0;
        repeat (2) step(1'b1, 1'b0, 32'h0, R_HOLD);
        chk("drop_addr_held", bus.addr, 32'h8);
        repeat (10) step(1'b1, 1'b0, 32'h0, R_FORCE);

        // Redirect in the same cycle as the response.
        wait_hold(32'h60);
        hold_en = 1'b0;
        step(1'b1, 1'b1, 32'h103, R_FORCE);
        repeat (4) step(1'b1, 1'b0, 32'h0, R_FORCE);

        // Further redirects while dropping: only the newest target survives.
        wait_hold(32'h10C);
        step(1'b1, 1'b1, 32'h300, R_HOLD);
        hold_en = 1'b0;
        step(1'b1, 1'b1, 32'h20, R_HOLD);
        step(1'b1, 1'b1, 32'h80, R_HOLD);
        step(1'b1, 1'b0, 32'h0, R_HOLD);
        step(1'b1, 1'b0, 32'h0, R_FORCE);
        repeat (8) step(1'b1, 1'b0, 32'h0, R_FORCE);

        // PC wraps from the top of the address space.
        step(1'b1, 1'b1, 32'hFFFF_FFF9, R_FORCE);
        repeat (6) step(1'b1, 1'b0, 32'h0, R_FORCE);

        // Asynchronous reset in the middle of a request.
        wait_hold(32'h10);
        #2;
        do_reset();
        repeat (12) step(1'b1, 1'b0, 32'h0, R_AUTO);

        // Random decode back-pressure, cache latency and redirects.
        for (int i = 0; i < 3000; i++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            if ((i % 500) < 20) rdy = 1'b0;
            redir = ($urandom_range(0, 15) == 0);
            tgt   = $urandom;
            step(rdy, redir, tgt, R_AUTO);
        end
        repeat (20) step(1'b1, 1'b0, 32'h0, R_AUTO);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
